// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential LEGv8 execute unit.
package alu_pkg;

  localparam int unsigned WIDTH_DEF     = 64;
  localparam int unsigned ALUOPSIZE_DEF = 5;
  localparam int unsigned FLAGSIZE_DEF  = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [4:0] {
    OP_AND = 5'b00000,
    OP_ORR = 5'b00001,
    OP_ADD = 5'b00010,
    OP_XOR = 5'b00011,
    OP_LSR = 5'b00100,
    OP_LSL = 5'b01000,
    OP_SUB = 5'b10000,
    OP_MUL = 5'b10001
  } aluop_e;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Radix-2 shift-add multiplier: start loads operands, done pulses on the
// WIDTH-th running cycle with the final partial sum presented combinationally.
module seq_alu_mul #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  // Last step is folded into the output so the result is usable in the done cycle.
  assign done       = r_run && (r_cnt == CW'(WIDTH - 1));
  assign product    = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (done) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked, registered LEGv8 execute unit with iterative MUL and an
// architectural NZCV flags register.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned ALUOPSIZE = ALUOPSIZE_DEF,
  parameter int unsigned FLAGSIZE  = FLAGSIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALUOPSIZE-1:0] alu_op,
  input  logic [WIDTH-1:0]     operand1,
  input  logic [WIDTH-1:0]     operand2,
  input  logic                 set_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 out_err,
  output logic [FLAGSIZE-1:0]  flags,
  output logic                 busy
);

  localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e              r_state;
  state_e              w_state_next;
  logic [WIDTH-1:0]    r_result;
  logic                r_err;
  logic                r_valid;
  logic [FLAGSIZE-1:0] r_flags;
  logic                r_set_flags;

  aluop_e              w_op;
  logic                w_accept;
  logic                w_mul_start;
  logic                w_mul_done;
  logic [WIDTH-1:0]    w_product;
  logic                w_load;
  logic [WIDTH-1:0]    w_res;
  logic                w_err;
  logic                w_c;
  logic                w_v;
  logic                w_we;
  logic [FLAGSIZE-1:0] w_flags_new;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH-1:0]    w_diff;
  logic [SHW-1:0]      w_shamt;

  assign w_op     = aluop_e'(alu_op);
  assign in_ready = rst_n && (r_state == IDLE) && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_sum    = {1'b0, operand1} + {1'b0, operand2};
  assign w_diff   = operand1 - operand2;
  assign w_shamt  = operand2[SHW-1:0];

  assign out_valid = r_valid;
  assign result    = r_result;
  assign out_err   = r_err;
  assign flags     = r_flags;
  assign busy      = (r_state == MUL_RUN);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (operand1),
    .b       (operand2),
    .done    (w_mul_done),
    .product (w_product)
  );

  always_comb begin
    w_state_next = r_state;
    w_mul_start  = 1'b0;
    w_load       = 1'b0;
    w_res        = '0;
    w_err        = 1'b0;
    w_c          = 1'b0;
    w_v          = 1'b0;
    w_we         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_op == OP_MUL) begin
            w_mul_start  = 1'b1;
            w_state_next = MUL_RUN;
          end else begin
            w_load = 1'b1;
            w_we   = set_flags;
            case (w_op)
              OP_AND: w_res = operand1 & operand2;
              OP_ORR: w_res = operand1 | operand2;
              OP_XOR: w_res = operand1 ^ operand2;
              OP_LSR: w_res = operand1 >> w_shamt;
              OP_LSL: w_res = operand1 << w_shamt;
              OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != operand1[WIDTH-1]);
              end
              OP_SUB: begin
                w_res = w_diff;
                w_c   = (operand1 >= operand2);
                w_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != operand1[WIDTH-1]);
              end
              default: begin
                w_err = 1'b1;
                w_we  = 1'b0;
              end
            endcase
          end
        end
      end
      MUL_RUN: begin
        if (w_mul_done) begin
          w_load       = 1'b1;
          w_res        = w_product;
          w_we         = r_set_flags;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_flags_new         = '0;
    w_flags_new[FLAG_N] = w_res[WIDTH-1];
    w_flags_new[FLAG_Z] = (w_res == '0);
    w_flags_new[FLAG_C] = w_c;
    w_flags_new[FLAG_V] = w_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_valid     <= 1'b0;
      r_flags     <= '0;
      r_set_flags <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_set_flags <= set_flags;
      if (w_load) begin
        r_result <= w_res;
        r_err    <= w_err;
        r_valid  <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_load && w_we) r_flags <= w_flags_new;
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Handshaked, registered execute unit for the LEGv8 datapath; the next generation of the combinational ALU.
- Width is parametrised. Results are registered behind a valid/ready handshake.
- Adds an iterative multi-cycle MUL and an architectural NZCV flags register, updated only by flag-setting instructions (ADDS/SUBS/ANDS style).
- Sits between decode/operand-fetch and writeback.

Parameters:
- WIDTH, 64, operand/result width (REGDATASIZE).
- ALUOPSIZE, 5, opcode width.
- FLAGSIZE, 4, flags width, order {N,Z,C,V}.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- alu_op  in  ALUOPSIZE  operation select.
- operand1  in  WIDTH  first operand.
- operand2  in  WIDTH  second operand / shift amount.
- set_flags  in  1  update the flags register with this op's flags.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- out_err  out  1  qualifies result; 1 = illegal opcode.
- flags  out  FLAGSIZE  architectural NZCV register.
- busy  out  1  multiply in progress.

Behaviour:
- Reset values (async, rst_n=0): out_valid=0, result=0, out_err=0, flags=0000, busy=0, state=IDLE, in_ready=0 while rst_n=0.
- Opcodes:
  - AND 00000; ORR 00001; ADD 00010; XOR 00011.
  - LSR 00100, logical right shift.
  - LSL 01000.
  - SUB 10000, operand1-operand2.
  - MUL 10001, low WIDTH bits of the product.
  - Any other value is illegal.
- Shifts: amount = operand2[$clog2(WIDTH)-1:0]; upper bits are ignored.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready. Opcode, operands and set_flags are captured on accept.
- Single-cycle ops: result and out_valid=1 appear the cycle after accept (latency 1). Back-to-back accepts are allowed when out_ready=1 (throughput 1/cycle).
- MUL:
  - state IDLE -> MUL_RUN on accept; busy=1, in_ready=0.
  - Radix-2 shift-add, exactly WIDTH cycles in MUL_RUN.
  - Then result is loaded, out_valid=1, state -> IDLE.
  - Latency WIDTH+1 cycles from accept.
- Output hold: while out_valid=1 && out_ready=0, result, out_err and out_valid are stable. The register is cleared (out_valid=0) on out_ready unless a new result loads in the same cycle.
- Flags computed from the WIDTH-bit result:
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = NOT borrow (1 when operand1 >= operand2 unsigned); V = signed overflow.
  - Logic, shift, MUL: C=0, V=0.
- Flags register update:
  - Written in the same cycle result loads, only if the captured set_flags=1.
  - Never written on illegal ops.
  - flags output always shows the register contents, not per-op values.
- Illegal opcode: latency 1, result=0, out_err=1, flags unchanged.
- Reset mid-MUL: partial product is discarded; state=IDLE, busy=0, out_valid=0.
- in_valid while in_ready=0: ignored; the requester must hold its request.

Decomposition:
- Package alu_pkg:
  - aluop_e enum with the encodings above.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - state_e {IDLE, MUL_RUN}.
  - Default WIDTH/ALUOPSIZE/FLAGSIZE constants.
- Sub-module seq_alu_mul:
  - Iterative multiplier with start/done.
  - Parameter WIDTH.
  - Done pulse after exactly WIDTH cycles.
  - Async reset clears its counter and accumulator.

Test Plan:
- SUB 20-4, set_flags=1, out_ready=1 -> next cycle result=16, out_valid=1, flags=0010.
- ADD 4 + (-20), set_flags=1 -> result=0xFFFF_FFFF_FFFF_FFF0, flags=1000. Then XOR 31^16 with set_flags=0 -> result=15, flags still 1000.
- LSL 3 by operand2=67 -> result=24 (amount 3). LSR 16 by 2 -> 4.
- MUL 7 * (-3) -> in_ready=0 and busy=1 for 64 cycles; then result=0xFFFF_FFFF_FFFF_FFEB, out_valid=1, 65 cycles after accept.
- Backpressure:
  - AND 31&64 issued with out_ready=0 for 5 cycles -> result=0 held stable, in_ready=0.
  - A second ORR is accepted in the cycle out_ready rises; its result 31 follows the next cycle.
- Reset and illegal opcode:
  - rst_n low at MUL cycle 20 -> out_valid=0, busy=0, flags=0000 immediately.
  - After reset, opcode 11111 -> out_err=1, result=0, flags unchanged.
